// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared types, defaults and the word-packing helper for the
//             mux sample packer.
//  Contents : MUX_SAMPLES_DEFAULT, MUX_FIFO_DEPTH_DEFAULT, MUX_SAMPLES_MAX,
//             pack_state_e, pack_word()
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

   localparam int MUX_SAMPLES_DEFAULT    = 8;
   localparam int MUX_FIFO_DEPTH_DEFAULT = 4;
   // Upper bound for SAMPLES; keeps the helper's fixed-width arguments legal.
   localparam int MUX_SAMPLES_MAX        = 16;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } pack_state_e;

   // Places the y1 lane above the y0 lane. The arguments are zero-extended
   // lanes of 'samples' bits; callers slice the low 2*samples bits.
   function automatic logic [63:0] pack_word(input logic [31:0] y1_bits,
                                              input logic [31:0] y0_bits,
                                              input int          samples);
      logic [63:0] w;
      w = 64'(y0_bits) & ((64'd1 << samples) - 64'd1);
      w = w | (64'(y1_bits) << samples);
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mux_word_fifo
//  Purpose  : Small register-based FIFO with a registered head word. Drop
//             policy on full is decided by the parent; a push while full is
//             only accepted together with a pop.
//  Ports    : clk_i, rst_ni (async, active-low), clr_i (sync flush)
//             push_i/data_i  - write side
//             pop_i          - remove head (ignored when empty)
//             head_o         - current head word
//             empty_o/full_o/count_o - occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module mux_word_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int                 C_PTR_W = $clog2(DEPTH);
   localparam logic [C_PTR_W:0]   C_DEPTH = (C_PTR_W + 1)'(DEPTH);
   localparam logic [C_PTR_W:0]   C_ONE   = (C_PTR_W + 1)'(1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mux_word_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0]   head_q, head_d;

   logic               w_pop;
   logic               w_push;
   logic [C_PTR_W-1:0] w_rd_next;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == C_DEPTH);
   assign w_pop     = pop_i & ~empty_o;
   assign w_push    = push_i & (~full_o | w_pop);
   assign w_rd_next = rd_ptr_q + 1'b1;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (clr_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         head_d   = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_d = w_rd_next;
         if (w_push && !w_pop)      count_d = count_q + C_ONE;
         else if (w_pop && !w_push) count_d = count_q - C_ONE;
         // Head tracks the entry rd_ptr will point at after this edge.
         // With one word left, a simultaneous push becomes the new head
         // directly since it has not landed in storage yet.
         if (w_pop) begin
            if (count_q > C_ONE) head_d = mem_q[w_rd_next];
            else if (w_push)     head_d = data_i;
         end else if (w_push && empty_o) begin
            head_d = data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (w_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = head_q;
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mux_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sample_packer
//  Purpose  : Samples the y0/y1 mux outputs on enabled cycles, packs SAMPLES
//             samples per lane into {y1_bits, y0_bits} words and streams the
//             completed words out of a small FIFO over valid/ready. Capture
//             never stalls; words completed into a full FIFO are dropped and
//             flagged by a sticky overflow bit.
//  Ports    : clk_i, rst_ni (async, active-low), en_i, clr_i (sync clear)
//             y0_i, y1_i            - mux outputs to sample
//             word_o/word_valid_o/word_ready_i - output stream
//             fill_o                - words held in the FIFO
//             overflow_o            - sticky word-dropped flag
//  Revision : 1.0 - initial release
// ============================================================================
module mux_sample_packer
   import mux_pkg::*;
#(
   parameter int SAMPLES    = MUX_SAMPLES_DEFAULT,
   parameter int FIFO_DEPTH = MUX_FIFO_DEPTH_DEFAULT
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          en_i,
   input  logic                          clr_i,
   input  logic                          y0_i,
   input  logic                          y1_i,
   output logic [2*SAMPLES-1:0]          word_o,
   output logic                          word_valid_o,
   input  logic                          word_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fill_o,
   output logic                          overflow_o
);

   localparam int                 C_CNT_W  = $clog2(SAMPLES);
   localparam logic [C_CNT_W-1:0] C_LAST   = C_CNT_W'(SAMPLES - 1);
   // Lanes hold only samples 0..SAMPLES-2; the final sample comes straight
   // from the input when the word is assembled.
   localparam int                 C_LANE_W = SAMPLES - 1;

   if (SAMPLES < 2 || SAMPLES > MUX_SAMPLES_MAX) begin : g_bad_samples
      $error("mux_sample_packer: SAMPLES out of range");
   end

   pack_state_e           state_q, state_d;
   logic [C_CNT_W-1:0]    cnt_q, cnt_d;
   logic [C_LANE_W-1:0]   y0_lane_q, y0_lane_d;
   logic [C_LANE_W-1:0]   y1_lane_q, y1_lane_d;
   logic                  overflow_q, overflow_d;

   logic                  w_take;
   logic                  w_done;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   logic [63:0]           w_packed;
   logic [2*SAMPLES-1:0]  w_word;
   logic                  unused_pack_hi;

   // clr_i wins over everything, so a sample or pop in its cycle is void.
   assign w_take = en_i & ~clr_i;
   assign w_done = w_take & (cnt_q == C_LAST);
   assign w_pop  = word_valid_o & word_ready_i & ~clr_i;
   // A completion into a full FIFO survives only if a slot frees this cycle.
   assign w_push = w_done & (~w_full | w_pop);

   assign w_packed = pack_word(32'({y1_i, y1_lane_q}), 32'({y0_i, y0_lane_q}), SAMPLES);
   assign w_word   = w_packed[2*SAMPLES-1:0];
   assign unused_pack_hi = ^w_packed[63:2*SAMPLES];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      y0_lane_d  = y0_lane_q;
      y1_lane_d  = y1_lane_q;
      overflow_d = overflow_q;
      if (clr_i) begin
         state_d    = IDLE;
         cnt_d      = '0;
         y0_lane_d  = '0;
         y1_lane_d  = '0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (en_i) state_d = COLLECT;
            COLLECT: state_d = COLLECT;
            default: state_d = IDLE;
         endcase
         if (w_take) begin
            // Shift toward bit 0 so that sample k ends up in bit k.
            y0_lane_d = (y0_lane_q >> 1) | (C_LANE_W'(y0_i) << (C_LANE_W - 1));
            y1_lane_d = (y1_lane_q >> 1) | (C_LANE_W'(y1_i) << (C_LANE_W - 1));
            cnt_d     = w_done ? '0 : cnt_q + 1'b1;
         end
         if (w_done && w_full && !w_pop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         y0_lane_q  <= '0;
         y1_lane_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         y0_lane_q  <= y0_lane_d;
         y1_lane_q  <= y1_lane_d;
         overflow_q <= overflow_d;
      end
   end

   mux_word_fifo #(
      .WIDTH (2*SAMPLES),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .push_i  (w_push),
      .data_i  (w_word),
      .pop_i   (w_pop),
      .head_o  (word_o),
      .empty_o (w_empty),
      .full_o  (w_full),
      .count_o (fill_o)
   );

   assign word_valid_o = ~w_empty;
   assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_sample_packer
//  Purpose  : Directed bench for mux_sample_packer. Expected words are queued
//             as stimulus is issued; a negedge monitor pops and compares each
//             word the DUT hands over.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sample_packer;

   localparam int SAMPLES    = 8;
   localparam int FIFO_DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        clr;
   logic        y0;
   logic        y1;
   logic        ready;
   logic [15:0] word;
   logic        valid;
   logic [2:0]  fill;
   logic        ovf;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   logic [15:0] sb_exp;
   logic [15:0] wv;

   mux_sample_packer #(
      .SAMPLES    (SAMPLES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .en_i         (en),
      .clr_i        (clr),
      .y0_i         (y0),
      .y1_i         (y1),
      .word_o       (word),
      .word_valid_o (valid),
      .word_ready_i (ready),
      .fill_o       (fill),
      .overflow_o   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One cycle of stimulus; returns 1 time unit after the rising edge.
   task automatic step(input logic e, input logic a, input logic b);
      en = e;
      y0 = a;
      y1 = b;
      @(posedge clk);
      #1;
   endtask

   // Drive samples first..last of word w: sample k is y0=w[k], y1=w[8+k].
   task automatic feed(input logic [15:0] w, input int first, input int last);
      for (int k = first; k <= last; k++) step(1'b1, w[k], w[8+k]);
   endtask

   // Scoreboard monitor: a handshake seen at the negedge pops one word.
   always @(negedge clk) begin
      if (rst_n && !clr && valid && ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_word actual=%0h required=none", word);
         end else begin
            sb_exp = exp_q.pop_front();
            check("sb_word", 32'(word), 32'(sb_exp));
         end
      end
   end

   initial begin
      logic [15:0] t3_words [5];
      t3_words = '{16'hA5C3, 16'h0F1E, 16'h7788, 16'hC001, 16'h5A5A};
      rst_n = 1'b1; en = 1'b0; clr = 1'b0; y0 = 1'b0; y1 = 1'b0; ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_fill",  32'(fill),  32'd0);
      check("reset_ovf",   32'(ovf),   32'd0);
      check("reset_word",  32'(word),  32'd0);
      rst_n = 1'b1;

      // 1: y0 alternates 1,0,..., y1 all ones -> FF55
      exp_q.push_back(16'hFF55);
      feed(16'hFF55, 0, 6);
      check("t1_valid_early", 32'(valid), 32'd0);
      feed(16'hFF55, 7, 7);
      en = 1'b0;
      check("t1_valid", 32'(valid), 32'd1);
      check("t1_word",  32'(word),  32'hFF55);
      check("t1_fill",  32'(fill),  32'd1);
      ready = 1'b1; step(1'b0, 1'b0, 1'b0); ready = 1'b0;
      check("t1_fill_after_pop", 32'(fill), 32'd0);

      // 2: enable every other cycle; disabled cycles carry opposite data
      exp_q.push_back(16'h00FF);
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) step(1'b1, 1'b1, 1'b0);
         else            step(1'b0, 1'b0, 1'b1);
         if (i == 13) check("t2_valid_before", 32'(valid), 32'd0);
         if (i == 14) begin
            check("t2_valid", 32'(valid), 32'd1);
            check("t2_word",  32'(word),  32'h00FF);
         end
      end
      check("t2_fill", 32'(fill), 32'd1);
      ready = 1'b1; step(1'b0, 1'b0, 1'b0); ready = 1'b0;
      check("t2_empty", 32'(valid), 32'd0);

      // 3: stalled consumer, five words back to back; fifth is dropped
      for (int n = 0; n < 5; n++) begin
         if (n < 4) exp_q.push_back(t3_words[n]);
         wv = t3_words[n];
         feed(wv, 0, 7);
         if (n < 4) begin
            check("t3_fill", 32'(fill), 32'(n + 1));
            check("t3_ovf_clear", 32'(ovf), 32'd0);
         end
      end
      en = 1'b0;
      check("t3_fill_sat", 32'(fill),  32'd4);
      check("t3_ovf_set",  32'(ovf),   32'd1);
      check("t3_head",     32'(word),  32'hA5C3);
      check("t3_valid",    32'(valid), 32'd1);

      // 4: full FIFO, pop in the same cycle as the next completion
      exp_q.push_back(16'h3C96);
      wv = 16'h3C96;
      feed(wv, 0, 6);
      ready = 1'b1;
      feed(wv, 7, 7);
      ready = 1'b0; en = 1'b0;
      check("t4_fill", 32'(fill), 32'd4);
      check("t4_head", 32'(word), 32'h0F1E);
      ready = 1'b1; step(1'b0, 1'b0, 1'b0); ready = 1'b0;
      check("t4_fill3", 32'(fill), 32'd3);
      check("t4_ovf",   32'(ovf),  32'd1);

      // 5: clear after 5 samples; that cycle's sample and pop are void
      feed(16'hFFFF, 0, 4);
      clr = 1'b1; ready = 1'b1;
      exp_q.delete();
      step(1'b1, 1'b1, 1'b1);
      clr = 1'b0; ready = 1'b0; en = 1'b0;
      check("t5_fill",  32'(fill),  32'd0);
      check("t5_valid", 32'(valid), 32'd0);
      check("t5_ovf",   32'(ovf),   32'd0);
      exp_q.push_back(16'h6B2D);
      feed(16'h6B2D, 0, 6);
      check("t5_valid_early", 32'(valid), 32'd0);
      feed(16'h6B2D, 7, 7);
      check("t5_word", 32'(word), 32'h6B2D);
      ready = 1'b1; step(1'b0, 1'b0, 1'b0); ready = 1'b0;

      // 6: async reset mid-cycle during a stalled handshake
      feed(16'hE817, 0, 7);
      en = 1'b0;
      check("t6_valid_pre", 32'(valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_valid_async", 32'(valid), 32'd0);
      check("t6_fill_async",  32'(fill),  32'd0);
      check("t6_word_async",  32'(word),  32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      exp_q.push_back(16'h4D71);
      feed(16'h4D71, 0, 6);
      check("t6_valid_early", 32'(valid), 32'd0);
      feed(16'h4D71, 7, 7);
      en = 1'b0;
      check("t6_valid", 32'(valid), 32'd1);
      ready = 1'b1; step(1'b0, 1'b0, 1'b0); ready = 1'b0;
      step(1'b0, 1'b0, 1'b0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
